// File: rtl/button_debounce.sv
// Synchronises, debounces and edge-detects NUM_BUTTONS raw push-buttons; release_pulse carries the
// release strobe ("release" is a reserved word). Define BUTTON_REPEAT_EN for auto-repeat press strobes.
module button_debounce #(
   parameter int NUM_BUTTONS     = 2,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int CNT_W           = 24,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] buttons,
   output logic [NUM_BUTTONS-1:0] level,
   output logic [NUM_BUTTONS-1:0] press,
   output logic [NUM_BUTTONS-1:0] release_pulse
);

   typedef enum logic [1:0] {STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO} state_t;

   localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 2) && ((DEBOUNCE_CYCLES >> CNT_W) == 0) &&
                              (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (PARAMS_OK) begin : g_ok
      logic [NUM_BUTTONS-1:0] meta;
      logic [NUM_BUTTONS-1:0] sync;

      // Two-flop synchroniser; nothing downstream ever sees the raw pins.
      always_ff @(posedge clk) begin
         if (reset) begin
            meta <= '0;
            sync <= '0;
         end else begin
            meta <= buttons;
            sync <= meta;
         end
      end

      for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
         state_t           state, state_nx;
         logic [CNT_W-1:0] cnt, cnt_nx;
         logic             level_q, level_nx;
         logic             press_q, press_nx;
         logic             release_q, release_nx;
         logic             repeat_fire;

         always_ff @(posedge clk) begin
            if (reset) begin
               state     <= STABLE_LO;
               cnt       <= '0;
               level_q   <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
            end else begin
               state     <= state_nx;
               cnt       <= cnt_nx;
               level_q   <= level_nx;
               press_q   <= press_nx;
               release_q <= release_nx;
            end
         end

         // A qualifying run must see the new level on DEBOUNCE_CYCLES consecutive samples;
         // any sample back at the old level abandons the run.
         always_comb begin
            state_nx   = state;
            cnt_nx     = cnt;
            level_nx   = level_q;
            press_nx   = 1'b0;
            release_nx = 1'b0;
            case (state)
               STABLE_LO: begin
                  if (sync[i]) begin
                     state_nx = QUAL_HI;
                     cnt_nx   = CNT_ONE;
                  end
               end
               QUAL_HI: begin
                  if (!sync[i]) begin
                     state_nx = STABLE_LO;
                     cnt_nx   = '0;
                  end else if (cnt == CNT_LAST) begin
                     state_nx = STABLE_HI;
                     cnt_nx   = '0;
                     level_nx = 1'b1;
                     press_nx = 1'b1;
                  end else if (cnt != '1) begin
                     cnt_nx = cnt + CNT_ONE;
                  end
               end
               STABLE_HI: begin
                  if (!sync[i]) begin
                     state_nx = QUAL_LO;
                     cnt_nx   = CNT_ONE;
                  end else if (repeat_fire) begin
                     press_nx = 1'b1;
                  end
               end
               QUAL_LO: begin
                  if (sync[i]) begin
                     state_nx = STABLE_HI;
                     cnt_nx   = '0;
                  end else if (cnt == CNT_LAST) begin
                     state_nx   = STABLE_LO;
                     cnt_nx     = '0;
                     level_nx   = 1'b0;
                     release_nx = 1'b1;
                  end else if (cnt != '1) begin
                     cnt_nx = cnt + CNT_ONE;
                  end
               end
               default: begin
                  state_nx = STABLE_LO;
                  cnt_nx   = '0;
               end
            endcase
         end

`ifdef BUTTON_REPEAT_EN
         localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
         localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
         localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
         localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

         logic [HOLD_W-1:0] hold, hold_nx;
         logic              repeating, repeating_nx;

         always_ff @(posedge clk) begin
            if (reset) begin
               hold      <= '0;
               repeating <= 1'b0;
            end else begin
               hold      <= hold_nx;
               repeating <= repeating_nx;
            end
         end

         // Hold timer runs only while the channel stays in STABLE_HI; first wait is the
         // delay, later waits are the period.
         always_comb begin
            hold_nx      = '0;
            repeating_nx = 1'b0;
            repeat_fire  = 1'b0;
            if (state == STABLE_HI && sync[i]) begin
               if (hold == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
                  repeat_fire  = 1'b1;
                  repeating_nx = 1'b1;
               end else begin
                  hold_nx      = hold + HOLD_W'(1);
                  repeating_nx = repeating;
               end
            end
         end
`else
         assign repeat_fire = 1'b0;
`endif

         assign level[i]         = level_q;
         assign press[i]         = press_q;
         assign release_pulse[i] = release_q;
      end
   end else begin : g_bad
      assign level         = '0;
      assign press         = '0;
      assign release_pulse = '0;
   end

endmodule
